// File: rtl/jtcontra_pkg.sv
// Shared definitions for the Contra sound-command path.
// IRQ mode encodings and sizing helpers used by the command queue.
package jtcontra_pkg;

  localparam int IRQ_PULSE = 0;
  localparam int IRQ_LEVEL = 1;
  localparam int IRQ_ACK   = 2;

  // Pointer width: a single-entry queue still needs a 1-bit address.
  function automatic int cmdq_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/jtcontra_cmdq_ram.sv
// Command storage: DEPTH x DW, one synchronous write port, asynchronous read.
// Contents are not reset; the queue pointers decide what is valid.
module jtcontra_cmdq_ram
  import jtcontra_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = cmdq_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/jtcontra_cmdq.sv
// Main-CPU to sound-CPU command queue with selectable IRQ behaviour and
// overflow handling. DEPTH=1, OVERWRITE=1, IRQ_MODE=0 behaves as the old latch.
module jtcontra_cmdq
  import jtcontra_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int IRQ_MODE  = IRQ_PULSE,
  parameter int OVERWRITE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_cen,
  input  logic                   wr_we,
  input  logic [DW-1:0]          wr_din,
  input  logic                   rd_cen,
  input  logic                   rd_re,
  input  logic                   irq_ack,
  input  logic                   ovf_clr,
  output logic [DW-1:0]          rd_dout,
  output logic                   snd_irq,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  localparam int AW = cmdq_aw(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_empty, r_full, r_ovf, r_irq;
  logic [DW-1:0] r_hold;

  logic          w_wr_req, w_rd_req, w_pop, w_push, w_ovf_wr, w_ovw, w_irq_evt;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr, w_wr_ptr_inc, w_rd_ptr_inc, w_newest;
  logic [DW-1:0] w_head;
  logic [LW-1:0] w_level_next;

  assign w_wr_req = wr_cen & wr_we;
  assign w_rd_req = rd_cen & rd_re;
  assign w_pop    = w_rd_req & ~r_empty;
  // A pop in the same cycle frees a slot, so a push into a full queue is accepted.
  assign w_push   = w_wr_req & (~r_full | w_pop);
  assign w_ovf_wr = w_wr_req & r_full & ~w_pop;
  assign w_ovw    = (OVERWRITE != 0) & w_ovf_wr;
  assign w_irq_evt = w_push | w_ovw;

  assign w_wr_ptr_inc = (DEPTH == 1) ? '0 : r_wr_ptr + AW'(1);
  assign w_rd_ptr_inc = (DEPTH == 1) ? '0 : r_rd_ptr + AW'(1);
  assign w_newest     = (DEPTH == 1) ? '0 : r_wr_ptr - AW'(1);

  assign w_ram_we   = w_push | w_ovw;
  assign w_ram_addr = w_push ? r_wr_ptr : w_newest;

  assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

  jtcontra_cmdq_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_addr),
    .wdata (wr_din),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_hold   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
        r_hold   <= w_head;
      end
      r_level <= w_level_next;
      r_empty <= (w_level_next == '0);
      r_full  <= (w_level_next == LW'(DEPTH));
    end
  end

  // Overflow wins over a coincident clear so the event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_ovf <= 1'b0;
    else if (w_ovf_wr)             r_ovf <= 1'b1;
    else if (wr_cen & ovf_clr)     r_ovf <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (IRQ_MODE == IRQ_LEVEL) begin
      r_irq <= (w_level_next != '0);
    end else if (IRQ_MODE == IRQ_ACK) begin
      if (w_irq_evt)              r_irq <= 1'b1;
      else if (rd_cen & irq_ack)  r_irq <= 1'b0;
    end else if (wr_cen) begin
      r_irq <= w_irq_evt;
    end
  end

  assign rd_dout = r_empty ? r_hold : w_head;
  assign snd_irq = r_irq;
  assign empty   = r_empty;
  assign full    = r_full;
  assign level   = r_level;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_jtcontra_cmdq.sv
// Scoreboard bench: a 4-deep drop/ack-IRQ queue and a 1-deep overwrite/pulse latch.
module tb_jtcontra_cmdq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_wr_cen, a_wr_we, a_rd_cen, a_rd_re, a_irq_ack, a_ovf_clr;
  logic [7:0] a_wr_din, a_rd_dout;
  logic       a_snd_irq, a_empty, a_full, a_ovf;
  logic [2:0] a_level;

  logic       b_wr_cen, b_wr_we, b_rd_cen, b_rd_re, b_irq_ack, b_ovf_clr;
  logic [7:0] b_wr_din, b_rd_dout;
  logic       b_snd_irq, b_empty, b_full, b_ovf;
  logic [0:0] b_level;

  jtcontra_cmdq #(.DW(8), .DEPTH(4), .IRQ_MODE(2), .OVERWRITE(0)) u_a (
    .clk(clk), .rst(rst), .wr_cen(a_wr_cen), .wr_we(a_wr_we), .wr_din(a_wr_din),
    .rd_cen(a_rd_cen), .rd_re(a_rd_re), .irq_ack(a_irq_ack), .ovf_clr(a_ovf_clr),
    .rd_dout(a_rd_dout), .snd_irq(a_snd_irq), .empty(a_empty), .full(a_full),
    .level(a_level), .ovf(a_ovf)
  );

  jtcontra_cmdq #(.DW(8), .DEPTH(1), .IRQ_MODE(0), .OVERWRITE(1)) u_b (
    .clk(clk), .rst(rst), .wr_cen(b_wr_cen), .wr_we(b_wr_we), .wr_din(b_wr_din),
    .rd_cen(b_rd_cen), .rd_re(b_rd_re), .irq_ack(b_irq_ack), .ovf_clr(b_ovf_clr),
    .rd_dout(b_rd_dout), .snd_irq(b_snd_irq), .empty(b_empty), .full(b_full),
    .level(b_level), .ovf(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitors: every pop the DUT accepts must present the next expected word.
  always @(negedge clk) begin
    if (!rst && a_rd_cen && a_rd_re && !a_empty) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_pop_unexpected: got %0h, required no pop", a_rd_dout);
      end else begin
        check("a_pop_data", {24'd0, a_rd_dout}, {24'd0, exp_a.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rd_cen && b_rd_re && !b_empty) begin
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_pop_unexpected: got %0h, required no pop", b_rd_dout);
      end else begin
        check("b_pop_data", {24'd0, b_rd_dout}, {24'd0, exp_b.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] d, input bit stored);
    a_wr_we  = 1'b1;
    a_wr_din = d;
    if (stored) exp_a.push_back(d);
    tick();
    a_wr_we  = 1'b0;
    a_wr_din = 8'h00;
  endtask

  task automatic a_pop();
    a_rd_re = 1'b1;
    tick();
    a_rd_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_wr_cen = 1'b1; a_wr_we = 1'b0; a_wr_din = 8'h00; a_rd_cen = 1'b1;
    a_rd_re = 1'b0; a_irq_ack = 1'b0; a_ovf_clr = 1'b0;
    b_wr_cen = 1'b0; b_wr_we = 1'b0; b_wr_din = 8'h00; b_rd_cen = 1'b0;
    b_rd_re = 1'b0; b_irq_ack = 1'b0; b_ovf_clr = 1'b0;
    tick(); tick();

    check("a_rst_empty", a_empty, 1);
    check("a_rst_full", a_full, 0);
    check("a_rst_level", a_level, 0);
    check("a_rst_ovf", a_ovf, 0);
    check("a_rst_irq", a_snd_irq, 0);
    check("a_rst_dout", a_rd_dout, 0);
    check("b_rst_empty", b_empty, 1);
    check("b_rst_irq", b_snd_irq, 0);
    check("b_rst_dout", b_rd_dout, 0);
    rst = 1'b0;
    tick();

    // In-order delivery and level tracking
    a_push(8'h11, 1); a_push(8'h22, 1); a_push(8'h33, 1);
    check("a_level_3", a_level, 3);
    check("a_irq_set", a_snd_irq, 1);
    a_pop(); check("a_level_2", a_level, 2);
    a_pop(); check("a_level_1", a_level, 1);
    a_pop(); check("a_level_0", a_level, 0);
    check("a_empty_end", a_empty, 1);
    check("a_hold_dout", a_rd_dout, 8'h33);
    a_irq_ack = 1'b1; tick(); a_irq_ack = 1'b0;
    check("a_ack_clear", a_snd_irq, 0);

    // Drop-on-full and overflow flag
    a_push(8'h01, 1); a_push(8'h02, 1); a_push(8'h03, 1); a_push(8'h04, 1);
    check("a_full_4", a_full, 1);
    check("a_ovf_before", a_ovf, 0);
    a_push(8'h05, 0);
    check("a_ovf_set", a_ovf, 1);
    check("a_level_drop", a_level, 4);
    a_pop(); a_pop(); a_pop(); a_pop();
    check("a_empty_after4", a_empty, 1);
    a_ovf_clr = 1'b1; tick(); a_ovf_clr = 1'b0;
    check("a_ovf_clr", a_ovf, 0);

    // Overflow beats coincident clear; push+pop at full
    a_push(8'hA1, 1); a_push(8'hA2, 1); a_push(8'hA3, 1); a_push(8'hA4, 1);
    a_ovf_clr = 1'b1; a_push(8'hEE, 0); a_ovf_clr = 1'b0;
    check("a_ovf_vs_clr", a_ovf, 1);
    a_ovf_clr = 1'b1; tick(); a_ovf_clr = 1'b0;
    check("a_ovf_clr2", a_ovf, 0);
    a_rd_re = 1'b1; a_push(8'h99, 1); a_rd_re = 1'b0;
    check("a_pp_level", a_level, 4);
    check("a_pp_full", a_full, 1);
    check("a_pp_ovf", a_ovf, 0);
    a_pop(); a_pop(); a_pop(); a_pop();
    check("a_pp_empty", a_empty, 1);

    // Asynchronous reset in the middle of traffic
    a_push(8'h31, 1); a_push(8'h32, 1);
    check("a_pre_rst_level", a_level, 2);
    #2 rst = 1'b1;
    #1;
    check("a_arst_empty", a_empty, 1);
    check("a_arst_level", a_level, 0);
    check("a_arst_irq", a_snd_irq, 0);
    check("a_arst_full", a_full, 0);
    exp_a.delete();
    @(posedge clk); #1 rst = 1'b0;
    tick();
    a_push(8'h5A, 1);
    check("a_first_after_rst", a_rd_dout, 8'h5A);
    check("a_level_after_rst", a_level, 1);
    check("a_irq_after_push", a_snd_irq, 1);

    // Write and ack together keep the IRQ; a lone ack clears it
    a_irq_ack = 1'b1; a_push(8'h7E, 1); a_irq_ack = 1'b0;
    check("a_irq_wr_ack", a_snd_irq, 1);
    a_irq_ack = 1'b1; tick(); a_irq_ack = 1'b0;
    check("a_irq_lone_ack", a_snd_irq, 0);
    a_pop(); a_pop();
    check("a_final_empty", a_empty, 1);

    // Legacy single latch: overwrite and pulsed IRQ
    b_wr_cen = 1'b1; b_wr_we = 1'b1; b_wr_din = 8'hA5; exp_b.push_back(8'hA5);
    tick();
    b_wr_cen = 1'b0; b_wr_we = 1'b0;
    check("b_irq_pulse1", b_snd_irq, 1);
    check("b_full", b_full, 1);
    check("b_dout_a5", b_rd_dout, 8'hA5);
    tick();
    check("b_irq_hold_no_cen", b_snd_irq, 1);
    b_wr_cen = 1'b1; tick();
    check("b_irq_low", b_snd_irq, 0);
    b_wr_we = 1'b1; b_wr_din = 8'h3C;
    void'(exp_b.pop_back()); exp_b.push_back(8'h3C);
    tick();
    b_wr_we = 1'b0;
    check("b_irq_pulse2", b_snd_irq, 1);
    check("b_dout_3c", b_rd_dout, 8'h3C);
    check("b_ovf", b_ovf, 1);
    check("b_level", b_level, 1);
    tick();
    check("b_irq_end", b_snd_irq, 0);
    b_rd_cen = 1'b1; b_rd_re = 1'b1; tick(); b_rd_re = 1'b0;
    check("b_empty_after_pop", b_empty, 1);
    check("b_hold_dout", b_rd_dout, 8'h3C);

    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
